// File: rtl/video_packet_send.sv
// Packs a 16-bit pixel stream into 32-bit transceiver words framed by FSYNC/LSYNC K-words.
// A frame sync flushes the line buffer and forces a guard interval of IDLE words.
module video_packet_send #(
   parameter int GUARD_CYCLES = 32,
   parameter int BUF_DEPTH    = 2048
) (
   input  logic        rx_clk,
   input  logic        rst,
   input  logic        vin_vs,
   input  logic        vin_de,
   input  logic [15:0] vin_data,
   input  logic [15:0] vin_width,
   output logic [31:0] gt_tx_data,
   output logic [3:0]  gt_tx_ctrl,
   output logic        overflow,
   output logic        busy
);

   localparam int WORDS = BUF_DEPTH / 2;
   localparam int AW    = $clog2(WORDS);
   localparam int CW    = AW + 1;
   localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

   localparam logic [31:0] FSYNC_WORD = 32'hFF0000BC;
   localparam logic [31:0] LSYNC_WORD = 32'hFF0002BC;
   localparam logic [31:0] IDLE_WORD  = 32'hFF0001BC;
   localparam logic [3:0]  K_CTRL     = 4'b0001;

   typedef enum logic [2:0] {IDLE, FSYNC, GUARD, LHEAD, LDATA} state_t;

   state_t        state, next_state;
   logic          vs_q, vs_armed, vs_rise, pend_fs;
   logic [GW-1:0] guard_cnt;
   logic [14:0]   data_cnt, line_w, w_now;
   logic [31:0]   out_data;
   logic [3:0]    out_ctrl;
   logic          rd_en, flush, accept, full, wr_word;
   logic [15:0]   lo_pix;
   logic          lo_valid;
   logic [31:0]   mem [WORDS];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] word_cnt;
   logic [31:0]   rd_data;
   logic          unused_width_lsb;

   assign unused_width_lsb = vin_width[0];
   assign w_now   = vin_width[15:1];
   // vs_armed masks the first sample after reset so a level already high is not an edge
   assign vs_rise = vin_vs & ~vs_q & vs_armed;
   assign flush   = (state == FSYNC);
   assign accept  = vin_de && (state != FSYNC) && (state != GUARD);
   assign full    = (word_cnt == CW'(WORDS));
   assign wr_word = accept && !full && lo_valid;

   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         vs_q     <= 1'b0;
         vs_armed <= 1'b0;
         pend_fs  <= 1'b0;
      end else begin
         vs_q     <= vin_vs;
         vs_armed <= 1'b1;
         if (vs_rise)
            pend_fs <= 1'b1;
         else if (state == FSYNC)
            pend_fs <= 1'b0;
      end
   end

   // Line buffer: pixels pair up in lo_pix and are stored as whole 32-bit words
   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         lo_pix   <= '0;
         lo_valid <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_cnt <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         lo_valid <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         word_cnt <= '0;
      end else begin
         if (accept && full)
            overflow <= 1'b1;
         if (accept && !full) begin
            if (lo_valid) begin
               lo_valid <= 1'b0;
            end else begin
               lo_pix   <= vin_data;
               lo_valid <= 1'b1;
            end
         end
         if (wr_word)
            wr_ptr <= (wr_ptr == AW'(WORDS - 1)) ? '0 : wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= (rd_ptr == AW'(WORDS - 1)) ? '0 : rd_ptr + AW'(1);
         case ({wr_word, rd_en})
            2'b10:   word_cnt <= word_cnt + CW'(1);
            2'b01:   word_cnt <= word_cnt - CW'(1);
            default: word_cnt <= word_cnt;
         endcase
      end
   end

   always_ff @(posedge rx_clk) begin
      if (wr_word)
         mem[wr_ptr] <= {vin_data, lo_pix};
      if (rd_en)
         rd_data <= mem[rd_ptr];
   end

   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         guard_cnt  <= '0;
         data_cnt   <= '0;
         line_w     <= '0;
         gt_tx_data <= IDLE_WORD;
         gt_tx_ctrl <= K_CTRL;
         busy       <= 1'b0;
      end else begin
         state      <= next_state;
         guard_cnt  <= (state == GUARD) ? guard_cnt + GW'(1) : '0;
         data_cnt   <= (state == LDATA) ? data_cnt + 15'd1 : '0;
         if (state == IDLE && next_state == LHEAD)
            line_w <= w_now;
         gt_tx_data <= out_data;
         gt_tx_ctrl <= out_ctrl;
         busy       <= (next_state != IDLE);
      end
   end

   // The first word is prefetched in LHEAD so LDATA streams without a bubble
   always_comb begin
      next_state = state;
      rd_en      = 1'b0;
      out_data   = IDLE_WORD;
      out_ctrl   = K_CTRL;
      case (state)
         IDLE: begin
            if (pend_fs)
               next_state = FSYNC;
            else if (w_now != 15'd0 && 32'(word_cnt) >= 32'(w_now))
               next_state = LHEAD;
         end
         FSYNC: begin
            out_data   = FSYNC_WORD;
            next_state = GUARD;
         end
         GUARD: begin
            if (guard_cnt == GW'(GUARD_CYCLES - 1))
               next_state = IDLE;
         end
         LHEAD: begin
            out_data   = LSYNC_WORD;
            rd_en      = 1'b1;
            next_state = LDATA;
         end
         LDATA: begin
            out_data = rd_data;
            out_ctrl = 4'b0000;
            if (data_cnt == line_w - 15'd1)
               next_state = IDLE;
            else
               rd_en = 1'b1;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_video_packet_send.sv
// Directed bench for video_packet_send: a monitor pops expected non-IDLE words from a
// scoreboard and also checks the run of IDLE words that preceded each one.
module tb_video_packet_send;

   localparam int GUARD = 32;
   localparam int DEPTH = 2048;
   localparam int INF   = 1 << 30;
   localparam logic [35:0] FSYNC_KEY = {4'b0001, 32'hFF0000BC};
   localparam logic [35:0] LSYNC_KEY = {4'b0001, 32'hFF0002BC};
   localparam logic [35:0] IDLE_KEY  = {4'b0001, 32'hFF0001BC};

   logic        rx_clk = 1'b0;
   logic        rst = 1'b1;
   logic        vin_vs = 1'b0;
   logic        vin_de = 1'b0;
   logic [15:0] vin_data = '0;
   logic [15:0] vin_width = '0;
   logic [31:0] gt_tx_data;
   logic [3:0]  gt_tx_ctrl;
   logic        overflow;
   logic        busy;
   logic [35:0] out_key;

   typedef struct {
      logic [35:0] key;
      int          min_idle;
      int          max_idle;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   idle_run = 0;
   bit   mon_en = 1'b0;

   video_packet_send #(.GUARD_CYCLES(GUARD), .BUF_DEPTH(DEPTH)) dut (
      .rx_clk     (rx_clk),
      .rst        (rst),
      .vin_vs     (vin_vs),
      .vin_de     (vin_de),
      .vin_data   (vin_data),
      .vin_width  (vin_width),
      .gt_tx_data (gt_tx_data),
      .gt_tx_ctrl (gt_tx_ctrl),
      .overflow   (overflow),
      .busy       (busy)
   );

   always #5 rx_clk = ~rx_clk;

   assign out_key = {gt_tx_ctrl, gt_tx_data};

   always @(negedge rx_clk) begin
      if (rst) begin
         idle_run = 0;
      end else if (mon_en) begin
         if (out_key == IDLE_KEY) begin
            idle_run++;
         end else begin
            checks++;
            assert (sb.size() != 0) else begin
               failures++;
               $error("[TB] FAIL unexpected_word observed=%h expected=none", out_key);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               checks++;
               assert (out_key === e.key) else begin
                  failures++;
                  $error("[TB] FAIL word observed=%h expected=%h", out_key, e.key);
               end
               checks++;
               assert (idle_run >= e.min_idle && idle_run <= e.max_idle) else begin
                  failures++;
                  $error("[TB] FAIL idle_gap observed=%0d expected=%0d..%0d", idle_run, e.min_idle, e.max_idle);
               end
            end
            idle_run = 0;
         end
      end
   end

   function automatic void expect_word(input logic [35:0] key, input int mn, input int mx);
      exp_t e;
      e.key = key;
      e.min_idle = mn;
      e.max_idle = mx;
      sb.push_back(e);
   endfunction

   // A line of n pixels starting at base: LSYNC then gap-free pixel pairs, low pixel first
   function automatic void expect_line(input logic [15:0] base, input int n, input int lsync_min_idle);
      logic [15:0] lo;
      expect_word(LSYNC_KEY, lsync_min_idle, INF);
      for (int j = 0; j < n / 2; j++) begin
         lo = base + 16'(2 * j);
         expect_word({4'b0000, lo + 16'd1, lo}, 0, 0);
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [35:0] observed, input logic [35:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         vin_de   = 1'b1;
         vin_data = base + 16'(i);
         @(negedge rx_clk);
      end
      vin_de = 1'b0;
   endtask

   task automatic pulse_vs();
      vin_vs = 1'b1;
      @(negedge rx_clk);
      vin_vs = 1'b0;
   endtask

   task automatic wait_word(input string tag, input logic [35:0] key, input int budget, output int lat);
      bit found = 1'b0;
      lat = -1;
      for (int c = 1; c <= budget && !found; c++) begin
         @(negedge rx_clk);
         if (out_key == key) begin
            found = 1'b1;
            lat = c;
         end
      end
      checks++;
      assert (found) else begin
         failures++;
         $error("[TB] FAIL %s observed=timeout expected=%h within %0d cycles", tag, key, budget);
      end
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit found = 1'b0;
      for (int c = 0; c < budget && !found; c++) begin
         @(negedge rx_clk);
         if (busy == 1'b0)
            found = 1'b1;
      end
      checks++;
      assert (found) else begin
         failures++;
         $error("[TB] FAIL %s observed=busy expected=idle within %0d cycles", tag, budget);
      end
   endtask

   task automatic wait_sb_empty(input string tag, input int budget);
      for (int c = 0; c < budget && sb.size() != 0; c++)
         @(negedge rx_clk);
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d pending expected=0", tag, sb.size());
      end
   endtask

   initial begin
      int lat;
      repeat (3) @(negedge rx_clk);
      checkOutput("reset_word", out_key, IDLE_KEY);
      checkOutput("reset_busy", 36'(busy), 36'd0);
      checkOutput("reset_overflow", 36'(overflow), 36'd0);
      rst = 1'b0;
      @(negedge rx_clk);
      mon_en = 1'b1;
      vin_width = 16'd8;
      repeat (3) @(negedge rx_clk);

      $display("[TB] basic frame and line");
      expect_word(FSYNC_KEY, 0, INF);
      pulse_vs();
      wait_word("fsync_basic", FSYNC_KEY, 10, lat);
      checkOutput("vs_to_fsync_latency", 36'(lat), 36'd2);
      checkOutput("busy_in_guard", 36'(busy), 36'd1);
      wait_idle("guard_end_basic", 100);
      expect_line(16'h0001, 8, GUARD);
      applyStimulus(16'h0001, 8);
      wait_sb_empty("line_basic", 50);

      $display("[TB] vs edge inside a packet");
      expect_line(16'h0011, 8, 1);
      applyStimulus(16'h0011, 8);
      wait_word("lsync_mid_vs", LSYNC_KEY, 50, lat);
      repeat (2) @(negedge rx_clk);
      expect_word(FSYNC_KEY, 1, 1);
      pulse_vs();
      wait_sb_empty("fsync_after_packet", 50);
      wait_idle("guard_end_mid_vs", 100);

      $display("[TB] pixels during guard are discarded");
      expect_word(FSYNC_KEY, 0, INF);
      pulse_vs();
      wait_word("fsync_guard_drop", FSYNC_KEY, 10, lat);
      repeat (4) @(negedge rx_clk);
      applyStimulus(16'h0100, 8);
      wait_idle("guard_end_drop", 100);
      repeat (20) @(negedge rx_clk);
      checkOutput("overflow_after_guard_drop", 36'(overflow), 36'd0);
      expect_line(16'h0021, 8, 1);
      applyStimulus(16'h0021, 8);
      wait_sb_empty("line_after_drop", 50);

      $display("[TB] buffer overrun");
      vin_width = 16'd4096;
      @(negedge rx_clk);
      for (int i = 0; i < DEPTH + 2; i++) begin
         vin_de   = 1'b1;
         vin_data = 16'(i);
         @(negedge rx_clk);
         if (i == DEPTH - 1)
            checkOutput("overflow_at_full", 36'(overflow), 36'd0);
         if (i == DEPTH)
            checkOutput("overflow_after_drop", 36'(overflow), 36'd1);
      end
      vin_de = 1'b0;
      repeat (20) @(negedge rx_clk);
      checkOutput("no_line_when_wide", 36'(busy), 36'd0);

      $display("[TB] zero width");
      vin_width = 16'd0;
      expect_word(FSYNC_KEY, 0, INF);
      pulse_vs();
      wait_word("fsync_zero_width", FSYNC_KEY, 10, lat);
      wait_idle("guard_end_zero_width", 100);
      applyStimulus(16'h0300, 200);
      repeat (20) @(negedge rx_clk);
      checkOutput("overflow_sticky", 36'(overflow), 36'd1);
      checkOutput("zero_width_not_busy", 36'(busy), 36'd0);

      $display("[TB] reset during line data");
      mon_en = 1'b0;
      vin_width = 16'd8;
      applyStimulus(16'h0041, 8);
      wait_word("lsync_before_reset", LSYNC_KEY, 50, lat);
      repeat (2) @(negedge rx_clk);
      rst = 1'b1;
      vin_vs = 1'b1;
      #1;
      checkOutput("async_reset_word", out_key, IDLE_KEY);
      checkOutput("async_reset_busy", 36'(busy), 36'd0);
      checkOutput("async_reset_overflow", 36'(overflow), 36'd0);
      @(negedge rx_clk);
      rst = 1'b0;
      @(negedge rx_clk);
      checkOutput("first_word_after_release", out_key, IDLE_KEY);
      checkOutput("busy_after_release", 36'(busy), 36'd0);
      sb.delete();
      mon_en = 1'b1;
      repeat (5) @(negedge rx_clk);
      vin_vs = 1'b0;
      repeat (5) @(negedge rx_clk);
      checkOutput("vs_high_at_release_ignored", 36'(busy), 36'd0);
      expect_word(FSYNC_KEY, 0, INF);
      pulse_vs();
      wait_word("fsync_after_reset", FSYNC_KEY, 10, lat);
      wait_idle("guard_end_after_reset", 100);
      expect_line(16'h0051, 8, GUARD);
      applyStimulus(16'h0051, 8);
      wait_sb_empty("line_after_reset", 50);
      repeat (10) @(negedge rx_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
